// File: rtl/mux2_arb_pkg.sv
// Shared types, request indices and sizing helpers for the two-requester
// burst arbiter and its mux datapath.
package mux2_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // One extra bit over clog2 so MAX_BURST=1 still gets a 1-bit counter.
   function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage : mux2_arb_pkg

// File: rtl/two_to_one_mux_dp.sv
// Parameterised 2:1 data-flow multiplexer; select REQ1 picks b_i, else a_i.
module two_to_one_mux_dp
   import mux2_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              sel_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   assign y_o = (sel_i == REQ1) ? b_i : a_i;

endmodule : two_to_one_mux_dp

// File: rtl/mux2_rr_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 valid/ready mux between two requesters.
// Define MUX2_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module mux2_rr_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy
);

   localparam int unsigned    CNT_W     = beat_cnt_width(MAX_BURST);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   arb_state_e       state_q;
   logic             sel_q;
   logic             prio_q;
   logic             busy_q;
   logic [CNT_W-1:0] beat_cnt_q;

   logic sel_d;
   logic prio_d;
   logic granted_c;
   logic g_valid_c;
   logic xfer_c;
   logic last_c;
   logic release_c;

   // Valid/ready steering toward the granted requester, plus arbitration decode.
   always_comb begin
      granted_c = 1'b0;
      g_valid_c = 1'b0;
      out_valid = 1'b0;
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      xfer_c    = 1'b0;
      last_c    = 1'b0;
      release_c = 1'b0;
      sel_d     = REQ0;
      prio_d    = prio_q;

      granted_c = (state_q == GRANT);
      g_valid_c = (sel_q == REQ1) ? in1_valid : in0_valid;
      out_valid = granted_c & g_valid_c;
      in0_ready = granted_c & (sel_q == REQ0) & out_ready;
      in1_ready = granted_c & (sel_q == REQ1) & out_ready;
      xfer_c    = out_valid & out_ready;
      last_c    = (beat_cnt_q == LAST_BEAT);
      // A dropped valid ends the burst even if the beat limit was not reached.
      release_c = granted_c & (~g_valid_c | (xfer_c & last_c));

      if (in0_valid && in1_valid) begin
         sel_d = prio_q;
      end else if (in1_valid) begin
         sel_d = REQ1;
      end else begin
         sel_d = REQ0;
      end

`ifdef MUX2_ARB_FIXED_PRIO_EN
      prio_d = REQ0;
`else
      prio_d = ~sel_q;
`endif
   end

   // Grant FSM with select, priority and beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= REQ0;
         prio_q     <= REQ0;
         busy_q     <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in0_valid || in1_valid) begin
                  state_q    <= GRANT;
                  busy_q     <= 1'b1;
                  sel_q      <= sel_d;
                  beat_cnt_q <= '0;
               end
            end
            GRANT: begin
               if (release_c) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  prio_q     <= prio_d;
                  beat_cnt_q <= '0;
               end else if (xfer_c) begin
                  beat_cnt_q <= beat_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   two_to_one_mux_dp #(
      .DATA_W (DATA_W)
   ) u_mux (
      .sel_i (sel_q),
      .a_i   (in0_data),
      .b_i   (in1_data),
      .y_o   (out_data)
   );

   assign sel  = sel_q;
   assign busy = busy_q;

endmodule : mux2_rr_arbiter

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: expected beats (select, data, cycle
// spacing) are queued with the stimulus and checked as transfers occur.
module tb_mux2_rr_arbiter;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned MAX_BURST = 4;

   typedef struct packed {
      logic              s;
      logic [DATA_W-1:0] d;
      logic [7:0]        dly;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in0_valid, in1_valid;
   logic [DATA_W-1:0] in0_data, in1_data;
   logic              in0_ready, in1_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              sel;
   logic              busy;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] src0[$];
   logic [DATA_W-1:0] src1[$];
   logic              en0, en1, rdy;
   int                n_chk = 0;
   int                n_fail = 0;
   int                cyc = 0;
   int                last_cyc = 0;

   mux2_rr_arbiter #(
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Drive requesters from their source queues after the edge, sample at negedge.
   task automatic tick();
      @(posedge clk);
      #1;
      in0_valid = en0 && (src0.size() != 0);
      in0_data  = (src0.size() != 0) ? src0[0] : '0;
      in1_valid = en1 && (src1.size() != 0);
      in1_data  = (src1.size() != 0) ? src1[0] : '0;
      out_ready = rdy;
      @(negedge clk);
      cyc++;
      if (in0_valid && in0_ready) void'(src0.pop_front());
      if (in1_valid && in1_ready) void'(src1.pop_front());
   endtask

   task automatic push_exp(input logic s, input logic [DATA_W-1:0] d, input int dly);
      exp_t e;
      e.s   = s;
      e.d   = d;
      e.dly = 8'(dly);
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      en0 = 1'b0;
      en1 = 1'b0;
      rdy = 1'b1;
      src0.delete();
      src1.delete();
      exp_q.delete();
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 8'h55;
      in1_data  = 8'hAA;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_chk++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL reset in0_ready: got %b want 0", in0_ready); end
      n_chk++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset in1_ready: got %b want 0", in1_ready); end
      n_chk++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset sel: got %b want 0", sel); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      apply_reset();
   endtask

   task automatic test_single();
      exp_t e;
      apply_reset();
      en0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src0.push_back(8'(8'h10 + i));
         push_exp(1'b0, 8'(8'h10 + i), (i == 0) ? 0 : ((i % MAX_BURST) == 0 ? 2 : 1));
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         tick();
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({sel, out_data} !== {e.s, e.d}) begin
               n_fail++;
               $display("FAIL single beat: got sel=%0d data=%02h want sel=%0d data=%02h", sel, out_data, e.s, e.d);
            end
            if (e.dly != 0) begin
               n_chk++;
               if (cyc - last_cyc !== int'(e.dly)) begin
                  n_fail++;
                  $display("FAIL single spacing: got %0d cycles want %0d", cyc - last_cyc, e.dly);
               end
            end
            last_cyc = cyc;
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single timeout: %0d beats missing want 0", exp_q.size()); end
   endtask

`ifndef MUX2_ARB_FIXED_PRIO_EN
   task automatic test_contention();
      exp_t e;
      apply_reset();
      en0 = 1'b1;
      en1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src0.push_back(8'(8'h20 + i));
         src1.push_back(8'(8'hA0 + i));
      end
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 4; k++) begin
            push_exp(b[0], (b[0] ? 8'hA0 : 8'h20) + 8'((b / 2) * 4 + k),
                     (b == 0 && k == 0) ? 0 : (k == 0 ? 2 : 1));
         end
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         tick();
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({sel, out_data} !== {e.s, e.d}) begin
               n_fail++;
               $display("FAIL contention beat: got sel=%0d data=%02h want sel=%0d data=%02h", sel, out_data, e.s, e.d);
            end
            if (e.dly != 0) begin
               n_chk++;
               if (cyc - last_cyc !== int'(e.dly)) begin
                  n_fail++;
                  $display("FAIL contention spacing: got %0d cycles want %0d", cyc - last_cyc, e.dly);
               end
            end
            n_chk++;
            if ((e.s ? in0_ready : in1_ready) !== 1'b0) begin
               n_fail++;
               $display("FAIL contention other_ready: got 1 want 0 during grant to %0d", e.s);
            end
            last_cyc = cyc;
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL contention timeout: %0d beats missing want 0", exp_q.size()); end
   endtask
`else
   task automatic test_fixed_prio();
      exp_t e;
      apply_reset();
      en0 = 1'b1;
      en1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         src0.push_back(8'(8'h40 + i));
         push_exp(1'b0, 8'(8'h40 + i), (i == 0) ? 0 : ((i % MAX_BURST) == 0 ? 2 : 1));
      end
      for (int i = 0; i < 4; i++) begin
         src1.push_back(8'(8'hD0 + i));
         push_exp(1'b1, 8'(8'hD0 + i), (i == 0) ? 2 : 1);
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         tick();
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({sel, out_data} !== {e.s, e.d}) begin
               n_fail++;
               $display("FAIL fixed beat: got sel=%0d data=%02h want sel=%0d data=%02h", sel, out_data, e.s, e.d);
            end
            if (e.dly != 0) begin
               n_chk++;
               if (cyc - last_cyc !== int'(e.dly)) begin
                  n_fail++;
                  $display("FAIL fixed spacing: got %0d cycles want %0d", cyc - last_cyc, e.dly);
               end
            end
            last_cyc = cyc;
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fixed timeout: %0d beats missing want 0", exp_q.size()); end
   endtask
`endif

   task automatic test_backpressure();
      exp_t e;
      int   nx = 0;
      int   stall = 0;
      apply_reset();
      en1 = 1'b1;
      for (int i = 0; i < 6; i++) src1.push_back(8'(8'hB0 + i));
      push_exp(1'b1, 8'hB0, 0);
      push_exp(1'b1, 8'hB1, 1);
      push_exp(1'b1, 8'hB2, 6);
      push_exp(1'b1, 8'hB3, 1);
      push_exp(1'b1, 8'hB4, 2);
      push_exp(1'b1, 8'hB5, 1);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         if (nx == 2 && stall < 5) begin
            rdy = 1'b0;
            stall++;
         end else begin
            rdy = 1'b1;
         end
         tick();
         if (!rdy) begin
            n_chk++;
            if ({out_valid, sel, busy, out_data} !== {1'b1, 1'b1, 1'b1, 8'hB2}) begin
               n_fail++;
               $display("FAIL stall hold: got valid=%b sel=%b busy=%b data=%02h want 1 1 1 b2",
                        out_valid, sel, busy, out_data);
            end
         end
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            nx++;
            n_chk++;
            if ({sel, out_data} !== {e.s, e.d}) begin
               n_fail++;
               $display("FAIL stall beat: got sel=%0d data=%02h want sel=%0d data=%02h", sel, out_data, e.s, e.d);
            end
            if (e.dly != 0) begin
               n_chk++;
               if (cyc - last_cyc !== int'(e.dly)) begin
                  n_fail++;
                  $display("FAIL stall spacing: got %0d cycles want %0d", cyc - last_cyc, e.dly);
               end
            end
            last_cyc = cyc;
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall timeout: %0d beats missing want 0", exp_q.size()); end
   endtask

   task automatic test_early_drop();
      exp_t e;
      apply_reset();
      en0 = 1'b1;
      en1 = 1'b1;
      src0.push_back(8'h30);
      src0.push_back(8'h31);
      for (int i = 0; i < 4; i++) src1.push_back(8'(8'hC0 + i));
      push_exp(1'b0, 8'h30, 0);
      push_exp(1'b0, 8'h31, 1);
      push_exp(1'b1, 8'hC0, 3);
      push_exp(1'b1, 8'hC1, 1);
      push_exp(1'b1, 8'hC2, 1);
      push_exp(1'b1, 8'hC3, 1);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         tick();
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            n_chk++;
            if ({sel, out_data} !== {e.s, e.d}) begin
               n_fail++;
               $display("FAIL drop beat: got sel=%0d data=%02h want sel=%0d data=%02h", sel, out_data, e.s, e.d);
            end
            if (e.dly != 0) begin
               n_chk++;
               if (cyc - last_cyc !== int'(e.dly)) begin
                  n_fail++;
                  $display("FAIL drop spacing: got %0d cycles want %0d", cyc - last_cyc, e.dly);
               end
            end
            last_cyc = cyc;
         end
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop timeout: %0d beats missing want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midburst();
      int nx = 0;
      int i  = 0;
      apply_reset();
      en1 = 1'b1;
      for (int k = 0; k < 6; k++) src1.push_back(8'(8'hE0 + k));
      while (nx < 2 && i < 50) begin
         tick();
         if (out_valid && out_ready) nx++;
         i++;
      end
      tick();
      n_chk++;
      if ({out_valid, sel, out_data} !== {1'b1, 1'b1, 8'hE2}) begin
         n_fail++;
         $display("FAIL midburst third beat: got valid=%b sel=%b data=%02h want 1 1 e2", out_valid, sel, out_data);
      end
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if ({out_valid, in0_ready, in1_ready, sel, busy} !== 5'b00000) begin
         n_fail++;
         $display("FAIL midburst async reset: got valid=%b r0=%b r1=%b sel=%b busy=%b want all 0",
                  out_valid, in0_ready, in1_ready, sel, busy);
      end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_single();
`ifndef MUX2_ARB_FIXED_PRIO_EN
      test_contention();
`else
      test_fixed_prio();
`endif
      test_backpressure();
      test_early_drop();
      test_reset_midburst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_mux2_rr_arbiter

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Sequencing controller that shares one 2:1 data-flow multiplexer between two valid/ready requesters.
- Owns the mux select as registered state; the select changes only between bursts, never mid-beat.
- Implements round-robin arbitration with bounded burst length and a single registered-grant FSM.
- Sits in front of any single-consumer sink that is fed by the 2:1 mux datapath.

Parameters:
- DATA_W, 8, width of each requester data bus and of the muxed output.
- MAX_BURST, 4, maximum beats granted per arbitration win; legal range 1..255.

Ports:
- clk  input  1  single system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  DATA_W  requester 0 data.
- in0_ready  output  1  requester 0 beat accepted this cycle.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  DATA_W  requester 1 data.
- in1_ready  output  1  requester 1 beat accepted this cycle.
- out_valid  output  1  muxed beat valid.
- out_data  output  DATA_W  muxed data, equal to sel ? in1_data : in0_data.
- out_ready  input  1  sink accepts a beat.
- sel  output  1  registered mux select: 0 = requester 0, 1 = requester 1.
- busy  output  1  a grant is active (FSM not IDLE).

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- State: FSM {IDLE, GRANT}; registers sel, prio (next-preferred requester), beat_cnt (width clog2(MAX_BURST)+1).
- Reset values: state=IDLE, sel=0, prio=0, beat_cnt=0. Outputs out_valid=0, in0_ready=0, in1_ready=0, busy=0.
- Reset assertion mid-burst returns everything to the reset state immediately, with no clock edge required. A beat in flight is dropped.
- IDLE: out_valid=0 and both ready outputs 0.
  - Only in0_valid set: next sel=0.
  - Only in1_valid set: next sel=1.
  - Both set: next sel=prio.
  - Any request present: go to GRANT with beat_cnt=0.
  - Grant latency is 1 cycle from valid to the first possible transfer.
- GRANT (granted index g=sel), all combinational:
  - out_valid = in_g_valid.
  - out_data = in_g_data.
  - in_g_ready = out_ready.
  - The other requester's ready = 0.
- Transfer: out_valid & out_ready. Each transfer increments beat_cnt.
- Release back to IDLE happens at the clock edge where either:
  - a transfer occurs with beat_cnt == MAX_BURST-1; or
  - in_g_valid == 0 (the requester has dropped; a burst is treated as ended).
- On release, prio = ~g. This gives strict alternation under continuous contention.
- One bubble cycle (IDLE) always separates consecutive bursts.
- Back-pressure: out_ready=0 stalls in GRANT indefinitely. beat_cnt holds, sel holds, and no release occurs while in_g_valid stays 1.
- Simultaneous release and a new request: the requester is seen in the following IDLE cycle, never in the same cycle.
- MAX_BURST=1: every grant is exactly one transfer.
- busy = (state == GRANT).

Optional Feature:
- Macro: MUX2_ARB_FIXED_PRIO_EN.
- Defined: when both requesters are valid in IDLE, sel=0 always, and prio is unused and held at 0. Burst limit and release rules are unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Shared package mux2_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - function beat_cnt_width(MAX_BURST);
  - constants REQ0=1'b0 and REQ1=1'b1.
- One natural sub-module: two_to_one_mux_dp, a parameterised DATA_W data-flow 2:1 mux, instantiated for out_data.
- The ready/valid steering stays in the top module.

Test Plan:
- Reset: assert rst mid-burst (3rd beat granted to requester 1) -> outputs 0, sel=0, busy=0 immediately, with no clk edge needed.
- Single requester: in0_valid held 1, data 0x10..0x17, out_ready=1, MAX_BURST=4 -> 4 beats (0x10-0x13), 1 idle cycle, then 4 more beats (0x14-0x17); sel=0 throughout.
- Contention round-robin: both valid from reset, out_ready=1 -> bursts granted 0,1,0,1, each 4 beats with one bubble between; in_other_ready never 1 during another's grant.
- Back-pressure: grant to requester 1, out_ready=0 for 5 cycles after beat 2 -> beat_cnt stays 2, out_data stable, sel=1; resumes and completes beats 3-4 after out_ready returns.
- Early drop: requester 0 granted, in0_valid drops after 2 beats while in1_valid=1 -> IDLE next cycle, then sel=1 grant.
- Feature build with MUX2_ARB_FIXED_PRIO_EN: both valid continuously -> sel always 0; requester 1 never granted while in0_valid stays 1.
